// File: rtl/lmul_pkg.sv
// -----------------------------------------------------------------------------
// lmul_pkg
// Shared definitions for the L-Mul reduction stage: bf16 field layout,
// special encodings and the accumulator FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package lmul_pkg;

    // bf16 field layout: {sign, exp[7:0], mant[6:0]}
    localparam int BF16_W   = 16;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 7;
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 7;
    localparam int MAN_MSB  = 6;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam logic [BF16_W-1:0] QNAN = 16'h7FC0;
    localparam logic [BF16_W-1:0] PINF = 16'h7F80;
    localparam logic [BF16_W-1:0] NINF = 16'hFF80;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // NaN and Inf share the all-ones exponent; both are treated alike here.
    function automatic logic is_special(input logic [BF16_W-1:0] v);
        return v[EXP_MSB:EXP_LSB] == EXP_MAX;
    endfunction

endpackage

// File: rtl/lmul_lzc.sv
// -----------------------------------------------------------------------------
// lmul_lzc
// Leading-zero counter used by the accumulator renormalization.
// Ports:
//   i_din  in  W   value to scan (MSB first)
//   o_cnt  out CW  number of leading zeros; W when i_din is all zeros
// -----------------------------------------------------------------------------
module lmul_lzc #(
    parameter int W  = 17,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_din,
    output logic [CW-1:0] o_cnt
);

    // Ascending scan: the highest set bit is the last to write o_cnt.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_din[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lmul_accum.sv
// -----------------------------------------------------------------------------
// lmul_accum
// Sums LEN consecutive bf16 products into one bf16 dot-product and presents it
// on a valid/ready output. One term per clock; the result is held until taken.
// Ports:
//   clk      in   1   clock, rising edge
//   rstn     in   1   synchronous active-low reset
//   i_valid  in   1   i_p holds a valid product
//   i_p      in   16  bf16 product
//   o_ready  out  1   a term can be accepted this cycle
//   o_valid  out  1   o_sum/o_flag valid
//   o_sum    out  16  bf16 dot-product result
//   o_flag   out  1   NaN/Inf input seen or accumulator overflow in this sum
//   i_ready  in   1   consumer takes o_sum this cycle
// -----------------------------------------------------------------------------
module lmul_accum
    import lmul_pkg::*;
#(
    parameter int BF16_WIDTH = 16,
    parameter int LEN        = 784,
    parameter int ACC_MAN    = 16,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_valid,
    input  logic [BF16_WIDTH-1:0] i_p,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [BF16_WIDTH-1:0] o_sum,
    output logic                  o_flag,
    input  logic                  i_ready
);

    localparam int SUM_W = ACC_MAN + 1;            // room for the add carry-out
    localparam int LZ_W  = $clog2(SUM_W + 1);
    localparam int PAD_W = ACC_MAN - 1 - MAN_W;    // zero fill below the bf16 mantissa
    localparam int GRD   = ACC_MAN - 2 - MAN_W;    // first bit below the rounded lsb
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    // ------------------------------------------------------------------ state
    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sign;
    logic [EXP_W-1:0]     r_exp;     // 0 = zero, 255 = saturated Inf
    logic [ACC_MAN-1:0]   r_mant;    // 1.x form, hidden bit at the MSB
    logic                 r_nan;     // NaN/Inf input seen in this sum

    logic                 w_accept;
    logic                 w_clear;

    // ---------------------------------------------------------- term decode
    logic                 w_t_special;
    logic                 w_t_zero;
    logic                 w_t_sign;
    logic [EXP_W-1:0]     w_t_exp;
    logic [ACC_MAN-1:0]   w_t_mant;

    assign w_t_special = is_special(i_p);
    // Denormals flush to zero; specials are flagged and contribute nothing.
    assign w_t_zero    = (i_p[EXP_MSB:EXP_LSB] == '0) || w_t_special;
    assign w_t_sign    = i_p[SIGN_BIT];
    assign w_t_exp     = w_t_zero ? '0 : i_p[EXP_MSB:EXP_LSB];
    assign w_t_mant    = w_t_zero ? '0 : {1'b1, i_p[MAN_MSB:0], {PAD_W{1'b0}}};

    // ------------------------------------------------------- align and add
    logic                 w_acc_ge;
    logic                 w_l_sign, w_s_sign;
    logic [EXP_W-1:0]     w_l_exp, w_s_exp;
    logic [ACC_MAN-1:0]   w_l_mant, w_s_mant;
    logic [EXP_W-1:0]     w_diff;
    logic [ACC_MAN-1:0]   w_s_align;
    logic [SUM_W-1:0]     w_raw;
    logic [LZ_W-1:0]      w_lz;

    // Zero has exp 0 and mant 0, so a plain {exp,mant} compare orders magnitudes.
    assign w_acc_ge = {r_exp, r_mant} >= {w_t_exp, w_t_mant};

    assign w_l_sign = w_acc_ge ? r_sign   : w_t_sign;
    assign w_l_exp  = w_acc_ge ? r_exp    : w_t_exp;
    assign w_l_mant = w_acc_ge ? r_mant   : w_t_mant;
    assign w_s_sign = w_acc_ge ? w_t_sign : r_sign;
    assign w_s_exp  = w_acc_ge ? w_t_exp  : r_exp;
    assign w_s_mant = w_acc_ge ? w_t_mant : r_mant;

    assign w_diff    = w_l_exp - w_s_exp;
    assign w_s_align = (w_diff >= EXP_W'(ACC_MAN)) ? '0 : (w_s_mant >> w_diff);

    assign w_raw = (w_l_sign == w_s_sign) ? ({1'b0, w_l_mant} + {1'b0, w_s_align})
                                          : ({1'b0, w_l_mant} - {1'b0, w_s_align});

    lmul_lzc #(
        .W (SUM_W)
    ) u_lzc (
        .i_din (w_raw),
        .o_cnt (w_lz)
    );

    logic                 w_add_sign;
    logic [EXP_W-1:0]     w_add_exp;
    logic [ACC_MAN-1:0]   w_add_mant;
    int                   w_exp_calc;

    // Shifting left by the lzc puts the leading one at bit SUM_W-1; the final
    // right shift by one lands it at the hidden-bit position. With lz=0 this
    // is exactly the carry-out case (shift right 1, exp+1).
    always_comb begin
        w_exp_calc = int'(w_l_exp) + 1 - int'(w_lz);
        w_add_sign = w_l_sign;
        w_add_exp  = EXP_W'(w_exp_calc);
        w_add_mant = ACC_MAN'((w_raw << w_lz) >> 1);
        if ((w_raw == '0) || (w_exp_calc < 1)) begin
            w_add_sign = 1'b0;
            w_add_exp  = '0;
            w_add_mant = '0;
        end else if (w_exp_calc >= int'(EXP_MAX)) begin
            w_add_exp  = EXP_MAX;
            w_add_mant = {1'b1, {(ACC_MAN-1){1'b0}}};
        end
    end

    // ------------------------------------------------------- output rounding
    logic [MAN_W-1:0]     w_keep;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_rnd_up;
    logic [MAN_W:0]       w_rnd;
    logic [EXP_W-1:0]     w_rnd_exp;
    logic [BF16_WIDTH-1:0] w_res_sum;
    logic                 w_res_flag;

    assign w_keep    = r_mant[ACC_MAN-2 -: MAN_W];
    assign w_guard   = r_mant[GRD];
    assign w_sticky  = |r_mant[GRD-1:0];
    assign w_rnd_up  = w_guard & (w_sticky | w_keep[0]);
    assign w_rnd     = {1'b0, w_keep} + {{MAN_W{1'b0}}, w_rnd_up};
    // A carry out of the kept mantissa leaves w_rnd[MAN_W-1:0] at zero (2.0 -> 1.0 * 2).
    assign w_rnd_exp = r_exp + EXP_W'(w_rnd[MAN_W]);

    always_comb begin
        w_res_sum  = {r_sign, w_rnd_exp, w_rnd[MAN_W-1:0]};
        w_res_flag = r_nan;
        if (r_nan) begin
            w_res_sum  = QNAN;
        end else if (r_exp == EXP_MAX) begin
            w_res_sum  = r_sign ? NINF : PINF;
            w_res_flag = 1'b1;
        end else if (r_exp == '0) begin
            w_res_sum  = '0;
        end else if (w_rnd_exp == EXP_MAX) begin
            w_res_sum  = r_sign ? NINF : PINF;
            w_res_flag = 1'b1;
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_sum        = '0;
        o_flag       = 1'b0;
        case (r_state)
            ST_ACC: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                o_sum   = w_res_sum;
                o_flag  = w_res_flag;
                if (i_ready) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_ACC;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    // ------------------------------------------------------ accumulator regs
    always_ff @(posedge clk) begin
        if (!rstn || w_clear) begin
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_mant <= '0;
            r_nan  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            r_nan <= r_nan | w_t_special;
            // Once overflowed, the sum stays at Inf until it is taken.
            if (r_exp != EXP_MAX) begin
                r_sign <= w_add_sign;
                r_exp  <= w_add_exp;
                r_mant <= w_add_mant;
            end
        end
    end

endmodule

// File: tb/tb_lmul_accum.sv
module tb_lmul_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    // LEN=4 instance
    logic        a_valid, a_ready, a_ovalid, a_flag, a_iready;
    logic [15:0] a_p, a_sum;
    // default LEN=784 instance
    logic        b_valid, b_ready, b_ovalid, b_flag, b_iready;
    logic [15:0] b_p, b_sum;

    int n_checks = 0;
    int n_errors = 0;

    lmul_accum #(.LEN(4)) dut4 (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (a_valid),
        .i_p     (a_p),
        .o_ready (a_ready),
        .o_valid (a_ovalid),
        .o_sum   (a_sum),
        .o_flag  (a_flag),
        .i_ready (a_iready)
    );

    lmul_accum dut784 (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (b_valid),
        .i_p     (b_p),
        .o_ready (b_ready),
        .o_valid (b_ovalid),
        .o_sum   (b_sum),
        .o_flag  (b_flag),
        .i_ready (b_iready)
    );

    // Reference: exact integer arithmetic on (sign, exp, 16-bit 1.x mantissa),
    // normalised with loops, then round-to-nearest-even to bf16. Returns {flag, sum}.
    function automatic logic [16:0] ref_dot(input logic [15:0] t [4]);
        int as_, ae, am;
        bit nan, inf;
        int ts, te, tm, ls, le, lm, ss, se, sm, d, r, q, rem;
        as_ = 0; ae = 0; am = 0; nan = 0; inf = 0;
        for (int k = 0; k < 4; k++) begin
            ts = int'(t[k][15]);
            te = int'(t[k][14:7]);
            if (te == 255) begin
                nan = 1;
            end else if (!inf) begin
                tm = (te == 0) ? 0 : (128 + int'(t[k][6:0])) * 256;
                if (ae > te || (ae == te && am >= tm)) begin
                    ls = as_; le = ae; lm = am; ss = ts; se = te; sm = tm;
                end else begin
                    ls = ts; le = te; lm = tm; ss = as_; se = ae; sm = am;
                end
                d  = le - se;
                sm = (d >= 16) ? 0 : (sm >> d);
                r  = (ls == ss) ? lm + sm : lm - sm;
                if (r == 0) begin
                    as_ = 0; ae = 0; am = 0;
                end else begin
                    while (r >= 65536) begin r = r >> 1; le++; end
                    while (r < 32768)  begin r = r << 1; le--; end
                    if (le < 1) begin
                        as_ = 0; ae = 0; am = 0;
                    end else if (le >= 255) begin
                        inf = 1; as_ = ls;
                    end else begin
                        as_ = ls; ae = le; am = r;
                    end
                end
            end
        end
        if (nan) return {1'b1, 16'h7FC0};
        if (inf) return {1'b1, (as_ != 0) ? 16'hFF80 : 16'h7F80};
        if (ae == 0) return 17'h0;
        q   = am >> 8;
        rem = am & 255;
        if (rem > 128 || (rem == 128 && (q % 2) == 1)) q++;
        if (q == 256) begin q = 128; ae++; end
        if (ae >= 255) return {1'b1, (as_ != 0) ? 16'hFF80 : 16'h7F80};
        return {1'b0, 1'(as_), 8'(ae), 7'(q)};
    endfunction

    function automatic logic [15:0] rand_term();
        int sel;
        logic [7:0] e;
        logic s;
        logic [6:0] m;
        sel = $urandom_range(0, 19);
        s   = 1'($urandom_range(0, 1));
        m   = 7'($urandom_range(0, 127));
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel <= 3) e = 8'($urandom_range(250, 254));
        else               e = 8'($urandom_range(118, 136));
        return {s, e, m};
    endfunction

    // Drives four terms into dut4 (optional random idle gaps), waits for the
    // result (bounded), optionally stalls i_ready, then takes it.
    task automatic drive_sum4(input logic [15:0] t [4], input int max_gap, input int hold,
                              output logic [15:0] sum, output logic flag, output int lat,
                              output bit held_ok, output logic vld_after);
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) begin
                a_valid = 1'b0;
                @(negedge clk);
            end
            a_valid = 1'b1;
            a_p     = t[k];
            @(negedge clk);
        end
        a_valid = 1'b0;
        a_p     = 16'h0;
        lat = 1;
        while (a_ovalid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sum     = a_sum;
        flag    = a_flag;
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (a_sum !== sum || a_flag !== flag || a_ovalid !== 1'b1 || a_ready !== 1'b0)
                held_ok = 1'b0;
        end
        a_iready = 1'b1;
        @(negedge clk);
        a_iready  = 1'b0;
        vld_after = a_ovalid;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        n_checks++; if (a_ovalid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", a_ovalid); end
        n_checks++; if (a_sum !== 16'h0) begin n_errors++; $display("FAIL reset_sum: got %h want 0000", a_sum); end
        n_checks++; if (a_flag !== 1'b0) begin n_errors++; $display("FAIL reset_flag: got %b want 0", a_flag); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready4: got %b want 1", a_ready); end
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready784: got %b want 1", b_ready); end
        n_checks++; if (b_ovalid !== 1'b0) begin n_errors++; $display("FAIL reset_valid784: got %b want 0", b_ovalid); end
        $display("reset: o_ready=%b o_valid=%b o_sum=%h o_flag=%b", a_ready, a_ovalid, a_sum, a_flag);
    endtask

    task automatic test_directed();
        logic [15:0] dv [9][4] = '{
            '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80},
            '{16'h3F80, 16'hBF80, 16'h4000, 16'hC000},
            '{16'h3F80, 16'h3B80, 16'h0000, 16'h0000},
            '{16'h3F81, 16'h3B80, 16'h0000, 16'h0000},
            '{16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F},
            '{16'h3F80, 16'h7F80, 16'h3F80, 16'h3F80},
            '{16'hBF80, 16'hBF80, 16'h0000, 16'h0000},
            '{16'hFF7F, 16'hFF7F, 16'hFF7F, 16'hFF7F},
            '{16'h0001, 16'h3F80, 16'h0000, 16'h0000}};
        logic [15:0] ds [9] = '{16'h4080, 16'h0000, 16'h3F80, 16'h3F82, 16'h7F80,
                                16'h7FC0, 16'hC000, 16'hFF80, 16'h3F80};
        logic        df [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] t [4];
        logic [15:0] sum;
        logic flag, vld_after;
        int lat;
        bit held_ok;
        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < 4; k++) t[k] = dv[v][k];
            drive_sum4(t, 0, 0, sum, flag, lat, held_ok, vld_after);
            $display("directed %0d: %h %h %h %h -> o_sum=%h o_flag=%b lat=%0d",
                     v, t[0], t[1], t[2], t[3], sum, flag, lat);
            n_checks++; if (sum !== ds[v]) begin n_errors++; $display("FAIL dir%0d_sum: got %h want %h", v, sum, ds[v]); end
            n_checks++; if (flag !== df[v]) begin n_errors++; $display("FAIL dir%0d_flag: got %b want %b", v, flag, df[v]); end
            n_checks++; if (lat != 1) begin n_errors++; $display("FAIL dir%0d_latency: got %0d want 1", v, lat); end
            n_checks++; if (vld_after !== 1'b0) begin n_errors++; $display("FAIL dir%0d_valid_after_take: got %b want 0", v, vld_after); end
        end
    endtask

    task automatic test_hold();
        a_valid = 1'b1;
        a_p     = 16'h3F80;
        repeat (4) @(negedge clk);
        a_p = 16'h4000;   // keep offering terms while DONE
        for (int h = 0; h < 6; h++) begin
            n_checks++; if (a_ovalid !== 1'b1) begin n_errors++; $display("FAIL hold%0d_valid: got %b want 1", h, a_ovalid); end
            n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL hold%0d_ready: got %b want 0", h, a_ready); end
            n_checks++; if (a_sum !== 16'h4080) begin n_errors++; $display("FAIL hold%0d_sum: got %h want 4080", h, a_sum); end
            $display("hold %0d: o_valid=%b o_ready=%b o_sum=%h", h, a_ovalid, a_ready, a_sum);
            if (h < 5) @(negedge clk);
        end
        a_iready = 1'b1;
        @(negedge clk);
        a_iready = 1'b0;
        n_checks++; if (a_ovalid !== 1'b0) begin n_errors++; $display("FAIL hold_valid_after_take: got %b want 0", a_ovalid); end
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL hold_ready_after_take: got %b want 1", a_ready); end
        repeat (4) @(negedge clk);
        a_valid = 1'b0;
        n_checks++; if (a_ovalid !== 1'b1) begin n_errors++; $display("FAIL hold_next_valid: got %b want 1", a_ovalid); end
        n_checks++; if (a_sum !== 16'h4100) begin n_errors++; $display("FAIL hold_next_sum: got %h want 4100", a_sum); end
        $display("hold next sum: o_sum=%h o_flag=%b", a_sum, a_flag);
        a_iready = 1'b1;
        @(negedge clk);
        a_iready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] t [4];
        logic [15:0] sum;
        logic flag, vld_after;
        int lat;
        bit held_ok;
        // partial sum of 3F80 + 7F80 (sets the flag), then reset
        a_valid = 1'b1; a_p = 16'h3F80; @(negedge clk);
        a_p = 16'h7F80; @(negedge clk);
        a_valid = 1'b0;
        rstn = 1'b0; @(negedge clk);
        rstn = 1'b1; @(negedge clk);
        for (int k = 0; k < 4; k++) t[k] = 16'h4000;
        drive_sum4(t, 0, 0, sum, flag, lat, held_ok, vld_after);
        $display("reset mid-sum: 4000 x4 -> o_sum=%h o_flag=%b", sum, flag);
        n_checks++; if (sum !== 16'h4100) begin n_errors++; $display("FAIL rstmid_sum: got %h want 4100", sum); end
        n_checks++; if (flag !== 1'b0) begin n_errors++; $display("FAIL rstmid_flag: got %b want 0", flag); end
    endtask

    task automatic test_random();
        logic [15:0] t [4];
        logic [15:0] sum;
        logic [16:0] exp_v;
        logic flag, vld_after;
        int lat, hold;
        bit held_ok;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) t[k] = rand_term();
            exp_v = ref_dot(t);
            hold  = $urandom_range(0, 3);
            drive_sum4(t, 2, hold, sum, flag, lat, held_ok, vld_after);
            $display("random %0d: %h %h %h %h -> o_sum=%h o_flag=%b model=%h/%b",
                     n, t[0], t[1], t[2], t[3], sum, flag, exp_v[15:0], exp_v[16]);
            n_checks++; if (sum !== exp_v[15:0]) begin n_errors++; $display("FAIL rand%0d_sum: got %h want %h", n, sum, exp_v[15:0]); end
            n_checks++; if (flag !== exp_v[16]) begin n_errors++; $display("FAIL rand%0d_flag: got %b want %b", n, flag, exp_v[16]); end
            n_checks++; if (!held_ok || lat != 1) begin n_errors++; $display("FAIL rand%0d_hold: held_ok=%b lat=%0d want 1/1", n, held_ok, lat); end
        end
    endtask

    task automatic test_len784();
        int lat;
        b_valid = 1'b1;
        b_p     = 16'h3F80;
        repeat (784) @(negedge clk);
        b_valid = 1'b0;
        lat = 1;
        while (b_ovalid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("len784: 3F80 x784 -> o_sum=%h o_flag=%b lat=%0d", b_sum, b_flag, lat);
        n_checks++; if (b_sum !== 16'h4444) begin n_errors++; $display("FAIL len784_sum: got %h want 4444", b_sum); end
        n_checks++; if (b_flag !== 1'b0) begin n_errors++; $display("FAIL len784_flag: got %b want 0", b_flag); end
        n_checks++; if (lat != 1) begin n_errors++; $display("FAIL len784_latency: got %0d want 1", lat); end
        b_iready = 1'b1;
        @(negedge clk);
        b_iready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        a_valid  = 1'b0; a_p = 16'h0; a_iready = 1'b0;
        b_valid  = 1'b0; b_p = 16'h0; b_iready = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        test_len784();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
